// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a power-of-two FIFO: start bit, DATA_BITS LSB first, STOP_BITS stop bits.
// Define UART_PARITY_EN to insert a parity bit after the data (even, or odd when PARITY_ODD=1).
module uart_tx_fifo #(
   parameter int CLK_DIV    = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic                                  sys_clk,
   input  logic                                  rst,
   input  logic [DATA_BITS-1:0]                  wr_data,
   input  logic                                  wr_valid,
   output logic                                  wr_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
   output logic                                  busy,
   output logic                                  uart_tx
);

   localparam int BW = $clog2(CLK_DIV);
   localparam int NW = $clog2(DATA_BITS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1)
   begin : g_param_check
      $error("uart_tx_fifo: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]        r_wptr, r_rptr;
   logic [CW-1:0]        r_count;
   state_t               r_state, w_state_nxt;
   logic [BW-1:0]        r_baud, w_baud_nxt;
   logic [NW-1:0]        r_bit, w_bit_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic                 r_tx, w_tx_nxt;
   logic                 w_push, w_pop, w_not_empty, w_baud_end;
`ifdef UART_PARITY_EN
   logic                 r_par;
`endif

   assign w_not_empty = (r_count != '0);
   assign wr_ready    = (r_count < CW'(FIFO_DEPTH));
   assign w_push      = wr_valid && wr_ready;
   assign w_baud_end  = (r_baud == BW'(CLK_DIV-1));
   assign fifo_count  = r_count;
   assign busy        = (r_state != S_IDLE) || w_not_empty;
   assign uart_tx     = r_tx;

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_tx_nxt    = r_tx;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tx_nxt = 1'b1;
            if (w_not_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_START;
               w_tx_nxt    = 1'b0;
               w_baud_nxt  = '0;
               w_bit_nxt   = '0;
            end
         end
         S_START: begin
            if (w_baud_end) begin
               w_state_nxt = S_DATA;
               w_tx_nxt    = r_shift[0];
               w_baud_nxt  = '0;
               w_bit_nxt   = '0;
            end else begin
               w_baud_nxt = r_baud + BW'(1);
            end
         end
         S_DATA: begin
            if (w_baud_end) begin
               w_baud_nxt = '0;
               if (r_bit == NW'(DATA_BITS-1)) begin
                  w_bit_nxt = '0;
`ifdef UART_PARITY_EN
                  w_state_nxt = S_PARITY;
                  w_tx_nxt    = r_par;
`else
                  w_state_nxt = S_STOP;
                  w_tx_nxt    = 1'b1;
`endif
               end else begin
                  // Bit 1 of the current word becomes bit 0 after this shift.
                  w_bit_nxt   = r_bit + NW'(1);
                  w_shift_nxt = r_shift >> 1;
                  w_tx_nxt    = r_shift[1];
               end
            end else begin
               w_baud_nxt = r_baud + BW'(1);
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: begin
            if (w_baud_end) begin
               w_state_nxt = S_STOP;
               w_tx_nxt    = 1'b1;
               w_baud_nxt  = '0;
            end else begin
               w_baud_nxt = r_baud + BW'(1);
            end
         end
`endif
         S_STOP: begin
            if (w_baud_end) begin
               w_baud_nxt = '0;
               if (r_bit == NW'(STOP_BITS-1)) begin
                  w_bit_nxt = '0;
                  if (w_not_empty) begin
                     w_pop       = 1'b1;
                     w_state_nxt = S_START;
                     w_tx_nxt    = 1'b0;
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_tx_nxt    = 1'b1;
                  end
               end else begin
                  w_bit_nxt = r_bit + NW'(1);
               end
            end else begin
               w_baud_nxt = r_baud + BW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
      if (w_pop) w_shift_nxt = r_mem[r_rptr];
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_tx    <= 1'b1;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_tx    <= w_tx_nxt;
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage and shifter carry no reset; the control path alone decides what is valid.
   always_ff @(posedge sys_clk) begin
      if (w_push) r_mem[r_wptr] <= wr_data;
      r_shift <= w_shift_nxt;
`ifdef UART_PARITY_EN
      if (w_pop) r_par <= (^r_mem[r_rptr]) ^ (PARITY_ODD != 0);
`endif
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two configurations checked every cycle against a frame-level model.
module tb_uart_tx_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, wv0, wv1;
   logic [7:0] wd0;
   logic [4:0] wd1;
   logic       rdy0, rdy1, busy0, busy1, tx0, tx1;
   logic [3:0] cnt0;
   logic [2:0] cnt1;

   uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(8), .PARITY_ODD(0)) u0 (
      .sys_clk(clk), .rst(rst), .wr_data(wd0), .wr_valid(wv0), .wr_ready(rdy0),
      .fifo_count(cnt0), .busy(busy0), .uart_tx(tx0));

   uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(1)) u1 (
      .sys_clk(clk), .rst(rst), .wr_data(wd1), .wr_valid(wv1), .wr_ready(rdy1),
      .fifo_count(cnt1), .busy(busy1), .uart_tx(tx1));

`ifdef UART_PARITY_EN
   localparam int           FL0  = 44;
   localparam int           FL6  = 72;
   localparam logic [127:0] L55  = 128'h0F0F0F0F00F;
   localparam logic [127:0] L07  = 128'h0FFF00000FF;
   localparam logic [127:0] L6   = 128'h0FFFFF0FF000000FFF;
`else
   localparam int           FL0  = 40;
   localparam int           FL6  = 64;
   localparam logic [127:0] L55  = 128'h0F0F0F0F0F;
   localparam logic [127:0] L07  = 128'h0FFF00000F;
   localparam logic [127:0] L6   = 128'h0FFFFFFF000000FF;
`endif

   // Model: per instance a word queue plus the list of line levels for the frame in flight.
   localparam int CDIV = 4;
   int M_DBITS[2] = '{8, 5};
   int M_SBITS[2] = '{1, 2};
   int M_DEPTH[2] = '{8, 4};
   bit M_PODD[2]  = '{1'b0, 1'b1};
   int q[2][16];
   int qh[2], qn[2];
   bit seq[2][128];
   int sp[2], sl[2];
   bit mvalid = 1'b0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic add_lvl(input int k, input bit b, input int n);
      for (int i = 0; i < n; i++) begin
         seq[k][sl[k]] = b;
         sl[k]++;
      end
   endtask

   task automatic build(input int k, input int w);
      bit par, b;
      sp[k] = 0;
      sl[k] = 0;
      par   = 1'b0;
      add_lvl(k, 1'b0, CDIV);
      for (int i = 0; i < M_DBITS[k]; i++) begin
         b   = ((w >> i) & 1) != 0;
         par = par ^ b;
         add_lvl(k, b, CDIV);
      end
`ifdef UART_PARITY_EN
      add_lvl(k, par ^ M_PODD[k], CDIV);
`endif
      add_lvl(k, 1'b1, M_SBITS[k] * CDIV);
   endtask

   task automatic mstep(input int k, input bit r, input bit v, input int d);
      int pre;
      if (r) begin
         qh[k] = 0; qn[k] = 0; sp[k] = 0; sl[k] = 0;
      end else begin
         pre = qn[k];
         if (sp[k] < sl[k]) sp[k]++;
         if (sp[k] >= sl[k] && qn[k] > 0) begin
            build(k, q[k][qh[k]]);
            qh[k] = (qh[k] + 1) % 16;
            qn[k]--;
         end
         if (v && pre < M_DEPTH[k]) begin
            q[k][(qh[k] + qn[k]) % 16] = d;
            qn[k]++;
         end
      end
   endtask

   function automatic bit etx(input int k);
      return (sp[k] < sl[k]) ? seq[k][sp[k]] : 1'b1;
   endfunction

   function automatic bit ebusy(input int k);
      return (sp[k] < sl[k]) || (qn[k] > 0);
   endfunction

   always @(posedge clk) begin
      mstep(0, rst, wv0, int'(wd0));
      mstep(1, rst, wv1, int'(wd1));
      mvalid = 1'b1;
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("tx0",   128'(tx0),   128'(etx(0)));
         chk("cnt0",  128'(cnt0),  128'(qn[0]));
         chk("rdy0",  128'(rdy0),  128'(qn[0] < M_DEPTH[0]));
         chk("busy0", 128'(busy0), 128'(ebusy(0)));
         chk("tx1",   128'(tx1),   128'(etx(1)));
         chk("cnt1",  128'(cnt1),  128'(qn[1]));
         chk("rdy1",  128'(rdy1),  128'(qn[1] < M_DEPTH[1]));
         chk("busy1", 128'(busy1), 128'(ebusy(1)));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic capture(input int k, input int n, output logic [127:0] lg);
      lg = '0;
      for (int i = 0; i < n; i++) begin
         lg = {lg[126:0], (k == 0) ? tx0 : tx1};
         tick();
      end
   endtask

   task automatic wait_idle(input string nm, input int maxc);
      int n = 0;
      while ((busy0 || busy1) && n < maxc) begin
         tick();
         n++;
      end
      chk(nm, 128'(busy0 | busy1), 128'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] lg;
      int n;
      rst = 1'b1; wv0 = 1'b0; wv1 = 1'b0; wd0 = '0; wd1 = '0;
      repeat (3) tick();
      chk("rst_tx0",  128'(tx0),  128'(1));
      chk("rst_rdy0", 128'(rdy0), 128'(1));
      chk("rst_cnt0", 128'(cnt0), 128'(0));
      chk("rst_busy0",128'(busy0),128'(0));
      chk("rst_tx1",  128'(tx1),  128'(1));
      chk("rst_busy1",128'(busy1),128'(0));
      rst = 1'b0;
      tick();

      // Single frame 0x55: low one cycle after the push, busy clears one cycle after the frame.
      wv0 = 1'b1; wd0 = 8'h55; tick(); wv0 = 1'b0;
      chk("t1_k0_tx",  128'(tx0),  128'(1));
      chk("t1_k0_cnt", 128'(cnt0), 128'(1));
      tick();
      capture(0, FL0, lg);
      chk("t1_seq",   lg, L55);
      chk("t1_busy",  128'(busy0), 128'(0));
      chk("t1_cnt",   128'(cnt0),  128'(0));

      // Frame 0x07 pins the data/parity bit order.
      wv0 = 1'b1; wd0 = 8'h07; tick(); wv0 = 1'b0;
      tick();
      capture(0, FL0, lg);
      chk("t5_seq", lg, L07);

      // Burst of 10 words into depth 8.
      for (int i = 0; i < 10; i++) begin
         wv0 = 1'b1; wd0 = 8'h10 + 8'(i); tick();
      end
      wv0 = 1'b0;
      chk("t2_full_cnt", 128'(cnt0), 128'(8));
      chk("t2_full_rdy", 128'(rdy0), 128'(0));
      wait_idle("t2_idle", 1000);

      // Hold fifo_count at 3 while pushing on every pop edge; pointers wrap many times.
      for (int i = 0; i < 4; i++) begin
         wv0 = 1'b1; wd0 = 8'h30 + 8'(i); tick();
      end
      wv0 = 1'b0;
      chk("t3_fill", 128'(cnt0), 128'(3));
      for (int j = 0; j < 20; j++) begin
         n = 0;
         while (!(sl[0] > 0 && sp[0] == sl[0] - 1) && n < 200) begin
            tick();
            n++;
         end
         chk("t3_sync", 128'(n < 200), 128'(1));
         wv0 = 1'b1; wd0 = 8'h40 + 8'(j); tick(); wv0 = 1'b0;
         chk("t3_cnt", 128'(cnt0), 128'(3));
      end
      wait_idle("t3_idle", 2000);

      // Reset during data bit 3 of 0xA3 with four words queued.
      wv0 = 1'b1; wd0 = 8'hA3; tick();
      wd0 = 8'h11; tick();
      wd0 = 8'h22; tick();
      wd0 = 8'h33; tick();
      wd0 = 8'h44; tick();
      wv0 = 1'b0;
      chk("t4_cnt", 128'(cnt0), 128'(4));
      repeat (14) tick();
      chk("t4_bit3", 128'(tx0), 128'(0));
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t4_tx",   128'(tx0),   128'(1));
      chk("t4_cnt0", 128'(cnt0),  128'(0));
      chk("t4_busy", 128'(busy0), 128'(0));
      chk("t4_rdy",  128'(rdy0),  128'(1));
      wv0 = 1'b1; wd0 = 8'h3C; tick(); wv0 = 1'b0;
      wait_idle("t4_idle", 200);

      // Two stop bits, five data bits, back-to-back frames.
      wv1 = 1'b1; wd1 = 5'h1F; tick();
      wd1 = 5'h00; tick();
      wv1 = 1'b0;
      capture(1, FL6, lg);
      chk("t6_seq",  lg, L6);
      chk("t6_busy", 128'(busy1), 128'(0));
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
